// File: rtl/i2s_tx_if.sv
//------------------------------------------------------------------------------
// Module : i2s_tx_if
// Avalon-MM slave bus bundle used by the I2S transmitter register file.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface i2s_tx_if;
   logic        chipselect;
   logic        read;
   logic        write;
   logic [1:0]  address;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output chipselect, read, write, address, writedata,
      input  readdata
   );

   modport slave (
      input  chipselect, read, write, address, writedata,
      output readdata
   );
endinterface

`default_nettype wire

// File: rtl/i2s_tx.sv
//------------------------------------------------------------------------------
// Module : i2s_tx
// I2S master transmitter: 24-bit L/R pairs written over Avalon-MM are
// serialised in 64-SCK frames through a one-deep holding buffer.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module i2s_tx #(
   parameter int SCK_DIV = 8
) (
   input  wire logic  clk,
   input  wire logic  reset,
   i2s_tx_if.slave    bus,
   output logic       SCK,
   output logic       WS,
   output logic       SD
);

   localparam logic [1:0] c_ADDR_LEFT   = 2'd0;
   localparam logic [1:0] c_ADDR_RIGHT  = 2'd1;
   localparam logic [1:0] c_ADDR_STATUS = 2'd2;
   localparam logic [1:0] c_ADDR_CTRL   = 2'd3;
   localparam logic [7:0] c_SCK_TERM    = 8'(SCK_DIV - 1);

   logic [7:0]  r_sck_cnt;
   logic        r_sck;
   logic        r_ws;
   logic        r_sd;
   logic [5:0]  r_bit_cnt;
   logic        r_enable;
   logic        r_valid;
   logic        r_underrun;
   logic        r_overrun;
   logic [23:0] r_hold_l;
   logic [23:0] r_hold_r;
   logic [23:0] r_shift_l;
   logic [23:0] r_shift_r;
   logic [31:0] r_readdata;

   logic        w_wr;
   logic        w_rd;
   logic        w_wr_left;
   logic        w_wr_right;
   logic        w_wr_ctrl;
   logic        w_enable_nxt;
   logic        w_run;
   logic        w_tick;
   logic        w_fall;
   logic [5:0]  w_bit_nxt;
   logic [4:0]  w_slot;
   logic        w_load;
   logic        w_data_slot;
   logic        w_unused;

   assign w_wr         = bus.chipselect & bus.write;
   assign w_rd         = bus.chipselect & bus.read;
   assign w_wr_left    = w_wr && (bus.address == c_ADDR_LEFT);
   assign w_wr_right   = w_wr && (bus.address == c_ADDR_RIGHT);
   assign w_wr_ctrl    = w_wr && (bus.address == c_ADDR_CTRL);
   // A disabling CTRL write idles the serialiser on the same edge it lands.
   assign w_enable_nxt = w_wr_ctrl ? bus.writedata[0] : r_enable;
   assign w_run        = r_enable & w_enable_nxt;
   assign w_tick       = w_run && (r_sck_cnt == c_SCK_TERM);
   assign w_fall       = w_tick & r_sck;
   assign w_bit_nxt    = r_bit_cnt + 6'd1;
   assign w_slot       = w_bit_nxt[4:0];
   assign w_load       = w_fall && (w_bit_nxt == 6'd0);
   assign w_data_slot  = (w_slot >= 5'd1) && (w_slot <= 5'd24);
   assign w_unused     = ^bus.writedata[31:24];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sck_cnt <= 8'd0;
         r_sck     <= 1'b0;
         r_ws      <= 1'b1;
         r_sd      <= 1'b0;
         r_bit_cnt <= 6'd63;
         r_shift_l <= 24'd0;
         r_shift_r <= 24'd0;
      end else if (!w_run) begin
         r_sck_cnt <= 8'd0;
         r_sck     <= 1'b0;
         r_ws      <= 1'b1;
         r_sd      <= 1'b0;
         r_bit_cnt <= 6'd63;
      end else begin
         if (w_tick) begin
            r_sck_cnt <= 8'd0;
            r_sck     <= ~r_sck;
         end else begin
            r_sck_cnt <= r_sck_cnt + 8'd1;
         end
         if (w_fall) begin
            r_bit_cnt <= w_bit_nxt;
            r_ws      <= w_bit_nxt[5];
            if (w_load) begin
               // Slot 0 is the one-bit I2S delay, so the load itself emits 0.
               r_sd      <= 1'b0;
               r_shift_l <= r_valid ? r_hold_l : 24'd0;
               r_shift_r <= r_valid ? r_hold_r : 24'd0;
            end else if (w_data_slot && w_bit_nxt[5]) begin
               r_sd      <= r_shift_r[23];
               r_shift_r <= {r_shift_r[22:0], 1'b0};
            end else if (w_data_slot) begin
               r_sd      <= r_shift_l[23];
               r_shift_l <= {r_shift_l[22:0], 1'b0};
            end else begin
               r_sd      <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_enable   <= 1'b0;
         r_valid    <= 1'b0;
         r_underrun <= 1'b0;
         r_overrun  <= 1'b0;
         r_hold_l   <= 24'd0;
         r_hold_r   <= 24'd0;
      end else begin
         r_enable <= w_enable_nxt;
         if (w_wr_left) begin
            r_hold_l <= bus.writedata[23:0];
         end
         if (w_wr_right) begin
            r_hold_r <= bus.writedata[23:0];
         end
         // Later assignments win: a commit on the load edge refills the buffer.
         if (w_load) begin
            r_valid <= 1'b0;
         end
         if (w_wr_right) begin
            r_valid <= 1'b1;
         end
         if (w_wr_ctrl && bus.writedata[1]) begin
            r_underrun <= 1'b0;
         end
         if (w_load && !r_valid) begin
            r_underrun <= 1'b1;
         end
         if (w_wr_ctrl && bus.writedata[2]) begin
            r_overrun <= 1'b0;
         end
         if (w_wr_right && r_valid && !w_load) begin
            r_overrun <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_readdata <= 32'd0;
      end else if (w_rd) begin
         case (bus.address)
            c_ADDR_LEFT:   r_readdata <= {8'd0, r_hold_l};
            c_ADDR_RIGHT:  r_readdata <= {8'd0, r_hold_r};
            c_ADDR_STATUS: r_readdata <= {29'd0, r_overrun, r_underrun, ~r_valid};
            default:       r_readdata <= {31'd0, r_enable};
         endcase
      end
   end

   assign bus.readdata = r_readdata;
   assign SCK          = r_sck;
   assign WS           = r_ws;
   assign SD           = r_sd;

endmodule

`default_nettype wire

// File: tb/tb_i2s_tx.sv
//------------------------------------------------------------------------------
// Module : tb_i2s_tx
// Directed self-checking bench for the I2S transmitter.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_i2s_tx;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   logic SCK;
   logic WS;
   logic SD;
   int   checks    = 0;
   int   failures  = 0;
   int   cyc       = 0;
   bit   timed_out = 1'b0;

   i2s_tx_if bus_if ();

   i2s_tx #(.SCK_DIV(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if),
      .SCK   (SCK),
      .WS    (WS),
      .SD    (SD)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      bus_if.chipselect = 1'b1;
      bus_if.write      = 1'b1;
      bus_if.address    = a;
      bus_if.writedata  = d;
      @(posedge clk);
      @(negedge clk);
      bus_if.chipselect = 1'b0;
      bus_if.write      = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk);
      bus_if.chipselect = 1'b1;
      bus_if.read       = 1'b1;
      bus_if.address    = a;
      @(posedge clk);
      @(negedge clk);
      d = bus_if.readdata;
      bus_if.chipselect = 1'b0;
      bus_if.read       = 1'b0;
   endtask

   // Waits for the next SCK high-to-low transition, observed on negedge clk.
   task automatic wait_fall;
      int n;
      if (timed_out) return;
      n = 0;
      while (SCK !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      while (SCK !== 1'b0 && n < 80) begin @(negedge clk); n++; end
      if (SCK !== 1'b0 || n >= 80) begin
         checks++;
         failures++;
         timed_out = 1'b1;
         $display("FAIL sck_fall_timeout: SCK=%b after %0d clk, required a fall", SCK, n);
      end
   endtask

   task automatic wait_frame_start;
      logic prev;
      for (int i = 0; i < 70; i++) begin
         prev = WS;
         wait_fall();
         if (timed_out) return;
         if (prev === 1'b1 && WS === 1'b0) return;
      end
      checks++;
      failures++;
      timed_out = 1'b1;
      $display("FAIL frame_start_timeout: WS=%b, required a 1->0 edge", WS);
   endtask

   // Entered just after the frame-start fall (slot 0 visible on SD/WS).
   task automatic capture_frame(output logic [23:0] l, output logic [23:0] r,
                                output int bad_ws, output int bad_pad, output int per);
      int t;
      int slot;
      l = 24'd0; r = 24'd0; bad_ws = 0; bad_pad = 0; per = 0;
      t = cyc;
      for (int k = 0; k < 64; k++) begin
         if (k > 0) wait_fall();
         if (k == 1) per = cyc - t;
         slot = k % 32;
         if (WS !== (k >= 32)) bad_ws++;
         if (slot >= 1 && slot <= 24) begin
            if (k < 32) l = {l[22:0], SD};
            else        r = {r[22:0], SD};
         end else if (SD !== 1'b0) begin
            bad_pad++;
         end
      end
   endtask

   task automatic test_reset;
      logic [31:0] d;
      bus_if.chipselect = 1'b0;
      bus_if.read       = 1'b0;
      bus_if.write      = 1'b0;
      bus_if.address    = 2'd0;
      bus_if.writedata  = 32'd0;
      repeat (3) @(negedge clk);
      checks++; if (SCK !== 1'b0) begin failures++; $display("FAIL reset_sck: got %b want 0", SCK); end
      checks++; if (WS !== 1'b1) begin failures++; $display("FAIL reset_ws: got %b want 1", WS); end
      checks++; if (SD !== 1'b0) begin failures++; $display("FAIL reset_sd: got %b want 0", SD); end
      checks++; if (bus_if.readdata !== 32'd0) begin failures++; $display("FAIL reset_readdata: got %h want 0", bus_if.readdata); end
      reset = 1'b1;
      bus_read(2'd2, d);
      checks++; if (d !== 32'h1) begin failures++; $display("FAIL reset_status: got %h want 00000001", d); end
   endtask

   task automatic test_single_pair;
      logic [31:0] d;
      logic [23:0] l, r;
      int bw, bp, per, t0;
      bus_write(2'd0, 32'hFFA5A5A5);
      bus_write(2'd1, 32'h005A5A5A);
      bus_read(2'd0, d);
      checks++; if (d !== 32'h00A5A5A5) begin failures++; $display("FAIL left_readback: got %h want 00a5a5a5", d); end
      bus_read(2'd2, d);
      checks++; if (d !== 32'h0) begin failures++; $display("FAIL single_status_pending: got %h want 00000000", d); end
      bus_write(2'd3, 32'h1);
      t0 = cyc;
      wait_fall();
      checks++; if (cyc - t0 != 16) begin failures++; $display("FAIL first_fall_latency: got %0d clk want 16", cyc - t0); end
      checks++; if (WS !== 1'b0) begin failures++; $display("FAIL first_fall_ws: got %b want 0", WS); end
      capture_frame(l, r, bw, bp, per);
      checks++; if (l !== 24'hA5A5A5) begin failures++; $display("FAIL single_left: got %h want a5a5a5", l); end
      checks++; if (r !== 24'h5A5A5A) begin failures++; $display("FAIL single_right: got %h want 5a5a5a", r); end
      checks++; if (bw != 0 || bp != 0) begin failures++; $display("FAIL single_framing: ws_err=%0d pad_err=%0d want 0/0", bw, bp); end
      checks++; if (per != 16) begin failures++; $display("FAIL sck_period: got %0d clk want 16", per); end
      bus_read(2'd2, d);
      checks++; if (d !== 32'h1) begin failures++; $display("FAIL single_status_ready: got %h want 00000001", d); end
   endtask

   task automatic test_underrun;
      logic [31:0] d;
      logic [23:0] l, r;
      int bw, bp, per;
      wait_fall();
      checks++; if (WS !== 1'b0) begin failures++; $display("FAIL underrun_frame_start: WS got %b want 0", WS); end
      capture_frame(l, r, bw, bp, per);
      checks++; if (l !== 24'd0 || r !== 24'd0 || bp != 0) begin
         failures++; $display("FAIL underrun_sd_zero: left=%h right=%h pad_err=%0d want all zero", l, r, bp);
      end
      wait_fall();
      bus_read(2'd2, d);
      checks++; if (d !== 32'h3) begin failures++; $display("FAIL underrun_status: got %h want 00000003", d); end
      bus_write(2'd3, 32'h3);
      bus_read(2'd2, d);
      checks++; if (d !== 32'h1) begin failures++; $display("FAIL underrun_clear: got %h want 00000001", d); end
   endtask

   task automatic test_overrun;
      logic [31:0] d;
      logic [23:0] l, r;
      int bw, bp, per;
      bus_write(2'd0, 32'h123456);
      bus_write(2'd1, 32'h654321);
      bus_write(2'd0, 32'h000001);
      bus_write(2'd1, 32'h800000);
      bus_read(2'd2, d);
      checks++; if (d !== 32'h4) begin failures++; $display("FAIL overrun_status: got %h want 00000004", d); end
      wait_frame_start();
      capture_frame(l, r, bw, bp, per);
      checks++; if (l !== 24'h000001 || r !== 24'h800000) begin
         failures++; $display("FAIL overrun_second_pair: got %h/%h want 000001/800000", l, r);
      end
      bus_read(2'd2, d);
      checks++; if (d !== 32'h5) begin failures++; $display("FAIL overrun_sticky: got %h want 00000005", d); end
      bus_write(2'd3, 32'h5);
      bus_read(2'd2, d);
      checks++; if (d !== 32'h1) begin failures++; $display("FAIL overrun_clear: got %h want 00000001", d); end
   endtask

   task automatic test_simultaneous;
      logic [31:0] d;
      logic [23:0] l, r;
      int bw, bp, per, n0;
      wait_frame_start();
      n0 = cyc;
      bus_write(2'd0, 32'h111111);
      bus_write(2'd1, 32'h222222);
      bus_write(2'd3, 32'h7);
      while (cyc < n0 + 1023 && !timed_out) @(negedge clk);
      bus_if.chipselect = 1'b1;
      bus_if.write      = 1'b1;
      bus_if.address    = 2'd1;
      bus_if.writedata  = 32'h333333;
      @(posedge clk);
      @(negedge clk);
      bus_if.chipselect = 1'b0;
      bus_if.write      = 1'b0;
      checks++; if (WS !== 1'b0) begin failures++; $display("FAIL simul_load_edge: WS got %b want 0", WS); end
      bus_write(2'd0, 32'h444444);
      capture_frame(l, r, bw, bp, per);
      checks++; if (l !== 24'h111111 || r !== 24'h222222) begin
         failures++; $display("FAIL simul_prior_pair: got %h/%h want 111111/222222", l, r);
      end
      bus_read(2'd2, d);
      checks++; if (d !== 32'h0) begin failures++; $display("FAIL simul_status: got %h want 00000000", d); end
      wait_fall();
      capture_frame(l, r, bw, bp, per);
      checks++; if (l !== 24'h444444 || r !== 24'h333333) begin
         failures++; $display("FAIL simul_new_pair: got %h/%h want 444444/333333", l, r);
      end
      bus_read(2'd2, d);
      checks++; if (d !== 32'h1) begin failures++; $display("FAIL simul_status_after: got %h want 00000001", d); end
   endtask

   task automatic test_disable;
      logic [31:0] d;
      logic [23:0] l, r;
      int bw, bp, per, t0;
      bus_write(2'd0, 32'hFFFFFF);
      bus_write(2'd1, 32'hFFFFFF);
      wait_frame_start();
      bus_write(2'd0, 32'h0F0F0F);
      bus_write(2'd1, 32'hF0F0F0);
      for (int i = 0; i < 42; i++) wait_fall();
      checks++; if (WS !== 1'b1 || SD !== 1'b1) begin
         failures++; $display("FAIL disable_pre_slot: WS/SD got %b/%b want 1/1", WS, SD);
      end
      bus_write(2'd3, 32'h0);
      checks++; if (SCK !== 1'b0 || SD !== 1'b0 || WS !== 1'b1) begin
         failures++; $display("FAIL disable_idle: SCK/SD/WS got %b/%b/%b want 0/0/1", SCK, SD, WS);
      end
      repeat (20) @(negedge clk);
      checks++; if (SCK !== 1'b0) begin failures++; $display("FAIL disable_stays_idle: SCK got %b want 0", SCK); end
      bus_read(2'd2, d);
      checks++; if (d !== 32'h0) begin failures++; $display("FAIL disable_status_kept: got %h want 00000000", d); end
      bus_write(2'd3, 32'h1);
      t0 = cyc;
      wait_fall();
      checks++; if (cyc - t0 != 16 || WS !== 1'b0) begin
         failures++; $display("FAIL reenable_start: latency %0d WS %b want 16/0", cyc - t0, WS);
      end
      capture_frame(l, r, bw, bp, per);
      checks++; if (l !== 24'h0F0F0F || r !== 24'hF0F0F0 || bw != 0 || bp != 0) begin
         failures++; $display("FAIL reenable_pair: got %h/%h ws_err=%0d pad_err=%0d want 0f0f0f/f0f0f0/0/0", l, r, bw, bp);
      end
   endtask

   task automatic test_reset_mid;
      logic [31:0] d;
      bus_write(2'd0, 32'hFFFFFF);
      bus_write(2'd1, 32'hFFFFFF);
      bus_read(2'd3, d);
      checks++; if (d !== 32'h1) begin failures++; $display("FAIL ctrl_readback: got %h want 00000001", d); end
      repeat (40) @(negedge clk);
      checks++; if (SD !== 1'b1 || WS !== 1'b0) begin
         failures++; $display("FAIL mid_frame_pre_reset: SD/WS got %b/%b want 1/0", SD, WS);
      end
      #2 reset = 1'b0;
      #1;
      checks++; if (SCK !== 1'b0 || WS !== 1'b1 || SD !== 1'b0 || bus_if.readdata !== 32'd0) begin
         failures++; $display("FAIL async_reset: SCK/WS/SD/rd got %b/%b/%b/%h want 0/1/0/0", SCK, WS, SD, bus_if.readdata);
      end
      @(negedge clk);
      reset = 1'b1;
      bus_read(2'd2, d);
      checks++; if (d !== 32'h1) begin failures++; $display("FAIL post_reset_status: got %h want 00000001", d); end
      bus_read(2'd3, d);
      checks++; if (d !== 32'h0) begin failures++; $display("FAIL post_reset_ctrl: got %h want 00000000", d); end
      bus_read(2'd0, d);
      checks++; if (d !== 32'h0) begin failures++; $display("FAIL post_reset_left: got %h want 00000000", d); end
   endtask

   initial begin
      test_reset();
      test_single_pair();
      test_underrun();
      test_overrun();
      test_simultaneous();
      test_disable();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule

`default_nettype wire

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- I2S master transmitter: HPS writes 24-bit left/right sample pairs over Avalon-MM; the block generates SCK and WS and serialises the samples onto SD for an external DAC/codec.
- Pair-wise counterpart of the microphone I2S receiver; same 50 MHz fabric clock, same 64-SCK frame (32 bits per channel, 24 data bits MSB-first).
- One-deep holding buffer decouples HPS writes from frame timing; status flags report ready, underrun and overrun.

Parameters:
- SCK_DIV, 8, clk cycles per SCK half-period (SCK period = 2*SCK_DIV clk; default 320 ns, frame 1024 clk, about 48.8 kHz); legal range 2..255.

Ports:
- clk  in  1  fabric clock, 50 MHz; all logic on posedge
- reset  in  1  asynchronous, active-low reset
- chipselect  in  1  Avalon slave select
- read  in  1  Avalon read strobe
- write  in  1  Avalon write strobe
- address  in  2  register index
- writedata  in  32  write data
- readdata  out  32  registered read data
- SCK  out  1  I2S bit clock
- WS  out  1  word select (0 = left, 1 = right)
- SD  out  1  serial data; changes on SCK falling edge

Behaviour:
- Register map (writes require chipselect && write):
  - 0 LEFT: writes holdL <= writedata[23:0].
  - 1 RIGHT: writes holdR <= writedata[23:0] and commits the pair (valid <= 1). If valid was already 1, set overrun; the new pair replaces the old one.
  - 2 STATUS (read): {29'b0, overrun, underrun, ready}; ready = ~valid.
  - 3 CTRL: bit0 enable (read back); writing 1 to bit1 clears underrun, writing 1 to bit2 clears overrun.
- Reads: when chipselect && read, readdata <= selected register on the next posedge (1-cycle latency). Otherwise readdata holds. LEFT/RIGHT read back the holding values, zero-extended.
- Reset values: SCK=0, WS=1, SD=0, readdata=0, enable=0, valid=0, holdL=holdR=0, shift regs=0, underrun=overrun=0, sck_cnt=0, bit_cnt=63.
- SCK generation: while enable=1, sck_cnt counts 0..SCK_DIV-1. At the terminal count, SCK toggles and sck_cnt wraps. A toggle with SCK=1 is a "fall event".
- On each fall event:
  - bit_cnt <= bit_cnt+1 (6-bit, wraps 63 to 0).
  - WS <= new bit_cnt[5].
  - slot s = new bit_cnt[4:0].
  - SD <= channel shift-register MSB for s in 1..24, shifting left after each bit. SD <= 0 for s = 0 and for s in 25..31 (one-bit I2S delay after the WS edge).
- Frame load: on the fall event where bit_cnt wraps to 0 (start of left word):
  - If valid=1, shiftL <= holdL, shiftR <= holdR, valid <= 0.
  - Otherwise shiftL = shiftR = 0 and underrun <= 1.
- Simultaneous RIGHT write and frame load in the same clk: the load consumes the pre-write holding contents (or records underrun if valid was 0). The written pair lands in holding with valid=1. No overrun is flagged for that write.
- Disable (enable written 0), including mid-frame: on the next clk, SCK=0, WS=1, SD=0, sck_cnt=0, bit_cnt=63. Holding buffer and flags are kept. Re-enable starts a clean frame; the first fall event loads.
- Async reset mid-frame: all state returns to reset values immediately; no partial word completes.
- Writes to STATUS are ignored. Sticky flags clear only via CTRL or reset.

Test Plan:
- Reset and idle: assert reset mid-traffic -> SCK=0, WS=1, SD=0, readdata=0. Read STATUS -> 0x1 one clk after the read.
- Single pair: write LEFT=0xA5A5A5, RIGHT=0x5A5A5A, CTRL=1 -> WS falls at the first fall event. SD bits 1..24 = 101001011010010110100101, bits 25..31 = 0. WS rises after 32 SCK, then SD carries 0x5A5A5A MSB-first. SCK period = 16 clk. STATUS ready returns to 1 at the load.
- Underrun: enable with no pair written -> SD stays 0 for the whole frame, STATUS=0x3. Write CTRL=0x3 -> STATUS=0x1.
- Overrun: write two pairs before a frame load -> STATUS bit2=1; the second pair (e.g. 0x000001/0x800000) is the one transmitted.
- Simultaneous: drive a RIGHT write on the exact clk of the frame-load fall event with a prior pair valid -> the prior pair is sent this frame, the new pair next frame, overrun stays 0.
- Disable mid-frame: write CTRL=0 at slot 10 of the right word -> SCK/SD/WS = 0/0/1 the next clk. Re-enable -> a fresh left word begins at slot 0 with the held pair.
